// File: rtl/prv32_muldiv_seq_pkg.sv
// Shared encodings for the RV32M multi-cycle sequencer: ALU op codes, FSM states, op decode.
package prv32_muldiv_seq_pkg;

    localparam int unsigned ALUFN_W = 5;

    localparam logic [ALUFN_W-1:0] ALU_MUL    = 5'h10;
    localparam logic [ALUFN_W-1:0] ALU_MULH   = 5'h11;
    localparam logic [ALUFN_W-1:0] ALU_MULHSU = 5'h12;
    localparam logic [ALUFN_W-1:0] ALU_MULHU  = 5'h13;
    localparam logic [ALUFN_W-1:0] ALU_DIV    = 5'h14;
    localparam logic [ALUFN_W-1:0] ALU_DIVU   = 5'h15;
    localparam logic [ALUFN_W-1:0] ALU_REM    = 5'h16;
    localparam logic [ALUFN_W-1:0] ALU_REMU   = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // sel_hi: upper product word for MULH*, remainder for REM*
    typedef struct packed {
        logic is_m;
        logic is_div;
        logic sgn_a;
        logic sgn_b;
        logic sel_hi;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [ALUFN_W-1:0] op);
        op_dec_t d;
        d = '0;
        case (op)
            ALU_MUL:    d = '{is_m: 1'b1, is_div: 1'b0, sgn_a: 1'b1, sgn_b: 1'b1, sel_hi: 1'b0};
            ALU_MULH:   d = '{is_m: 1'b1, is_div: 1'b0, sgn_a: 1'b1, sgn_b: 1'b1, sel_hi: 1'b1};
            ALU_MULHSU: d = '{is_m: 1'b1, is_div: 1'b0, sgn_a: 1'b1, sgn_b: 1'b0, sel_hi: 1'b1};
            ALU_MULHU:  d = '{is_m: 1'b1, is_div: 1'b0, sgn_a: 1'b0, sgn_b: 1'b0, sel_hi: 1'b1};
            ALU_DIV:    d = '{is_m: 1'b1, is_div: 1'b1, sgn_a: 1'b1, sgn_b: 1'b1, sel_hi: 1'b0};
            ALU_DIVU:   d = '{is_m: 1'b1, is_div: 1'b1, sgn_a: 1'b0, sgn_b: 1'b0, sel_hi: 1'b0};
            ALU_REM:    d = '{is_m: 1'b1, is_div: 1'b1, sgn_a: 1'b1, sgn_b: 1'b1, sel_hi: 1'b1};
            ALU_REMU:   d = '{is_m: 1'b1, is_div: 1'b1, sgn_a: 1'b0, sgn_b: 1'b0, sel_hi: 1'b1};
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/prv32_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on the 64-bit accumulator.
module prv32_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_diff;
    logic            w_fits;

    // Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
        w_fits   = (w_rem_sh >= {1'b0, i_opnd});
        w_diff   = w_rem_sh[XLEN-1:0] - i_opnd;
        if (i_is_div) begin
            if (w_fits) begin
                o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/prv32_muldiv_seq.sv
// Multi-cycle RV32M sequencer: latches |a|,|b| and signs at accept, iterates 32 radix-2 steps,
// then sign-corrects and selects the result word; divide corner cases may finish at accept.
module prv32_muldiv_seq
    import prv32_muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ALUFN_W-1:0] alufn,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic               kill,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    r
);

    localparam int unsigned     CNT_W   = 5;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state, w_state_nxt;
    logic [2*XLEN-1:0] r_acc, w_acc_nxt, w_step_acc;
    logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
    logic [XLEN-1:0]   r_res, w_res_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_is_div, w_is_div_nxt;
    logic              r_sel_hi, w_sel_hi_nxt;
    logic              r_sa, w_sa_nxt;
    logic              r_sb, w_sb_nxt;
    logic              r_bzero, w_bzero_nxt;
    logic              r_ready, r_busy, r_done;

    op_dec_t           w_dec;
    logic              w_sa, w_sb, w_accept, w_ovf, w_special;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special_res;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

    prv32_muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    // Accept-time decode and RISC-V divide corner cases
    assign w_dec     = decode_op(alufn);
    assign w_sa      = w_dec.sgn_a & a[XLEN-1];
    assign w_sb      = w_dec.sgn_b & b[XLEN-1];
    assign w_abs_a   = w_sa ? (~a + XLEN'(1)) : a;
    assign w_abs_b   = w_sb ? (~b + XLEN'(1)) : b;
    assign w_accept  = start & w_dec.is_m & ~kill;
    assign w_ovf     = w_dec.sgn_a & (a == INT_MIN) & (b == '1);
    assign w_special = EARLY_OUT & w_dec.is_div & ((b == '0) | w_ovf);
    assign w_special_res = (b == '0) ? (w_dec.sel_hi ? a : '1)
                                     : (w_dec.sel_hi ? '0 : INT_MIN);

    // Sign correction; a zero divisor keeps the all-ones quotient unsigned
    assign w_prod    = (r_sa ^ r_sb) ? (~r_acc + (2*XLEN)'(1)) : r_acc;
    assign w_quo     = ((r_sa ^ r_sb) & ~r_bzero) ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    assign w_rem     = r_sa ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
    assign w_fix_res = r_is_div ? (r_sel_hi ? w_rem : w_quo)
                                : (r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_res_nxt    = r_res;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_sel_hi_nxt = r_sel_hi;
        w_sa_nxt     = r_sa;
        w_sb_nxt     = r_sb;
        w_bzero_nxt  = r_bzero;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_is_div_nxt = w_dec.is_div;
                    w_sel_hi_nxt = w_dec.sel_hi;
                    w_sa_nxt     = w_sa;
                    w_sb_nxt     = w_sb;
                    w_bzero_nxt  = (b == '0);
                    w_cnt_nxt    = '0;
                    w_acc_nxt    = {{XLEN{1'b0}}, (w_dec.is_div ? w_abs_a : w_abs_b)};
                    w_opnd_nxt   = w_dec.is_div ? w_abs_b : w_abs_a;
                    if (w_special) begin
                        w_res_nxt   = w_special_res;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt = w_step_acc;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        w_state_nxt = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_res_nxt   = w_fix_res;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sel_hi <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_res    <= w_res_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_sel_hi <= w_sel_hi_nxt;
            r_sa     <= w_sa_nxt;
            r_sb     <= w_sb_nxt;
            r_bzero  <= w_bzero_nxt;
            r_ready  <= (w_state_nxt == S_IDLE);
            r_busy   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign r     = r_res;

endmodule

// File: tb/tb_prv32_muldiv_seq.sv
// Directed self-checking bench for prv32_muldiv_seq: results, latency, kill, reset and start filtering.
module tb_prv32_muldiv_seq;
    import prv32_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [4:0]  alufn;
    logic [31:0] a, b, r;
    logic        ready, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int d0;

    prv32_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .alufn (alufn),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .r     (r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, measure cycles from accept to done.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        @(negedge clk);
        alufn = op; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom(); b = $urandom();
        if (exp_lat > 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq(tag, r, exp_r);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; alufn = '0; a = '0; b = '0;
        #12;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_done",  32'(done),  32'd0);
        check_eq("rst_r",     r,          32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("mul",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh",   ALU_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        run_op("div",    ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem",    ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu",   ALU_DIVU,   32'd100,      32'd7,        32'd14,       34);
        run_op("remu",   ALU_REMU,   32'd100,      32'd7,        32'd2,        34);
        run_op("div0",   ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem0",   ALU_REM,    32'd5,        32'd0,        32'd5,        1);
        run_op("divovf", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("removf", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        run_op("divu0",  ALU_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu0",  ALU_REMU,   32'd9,        32'd0,        32'd9,        1);

        // kill at RUN count 10
        @(negedge clk); alufn = ALU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check_eq("kill_ready", 32'(ready), 32'd1);
        check_eq("kill_busy",  32'(busy),  32'd0);
        check_eq("kill_done",  32'(done),  32'd0);
        check_eq("kill_r",     r,          32'd9);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("kill_nodone", 32'(done_cnt - d0), 32'd0);
        run_op("mul_after_kill", ALU_MUL, 32'd3, 32'd4, 32'd12, 34);

        // non-M op is ignored
        @(negedge clk); alufn = 5'h00; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check_eq("nonm_ready", 32'(ready), 32'd1);
        check_eq("nonm_busy",  32'(busy),  32'd0);

        // kill beats start in IDLE (early-out op would otherwise finish immediately)
        @(negedge clk); alufn = ALU_DIV; a = 32'd5; b = 32'd0; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1; start = 1'b0; kill = 1'b0;
        check_eq("killstart_ready", 32'(ready), 32'd1);
        check_eq("killstart_done",  32'(done),  32'd0);
        check_eq("killstart_r",     r,          32'd12);

        // start held while busy: only one op completes
        d0 = done_cnt;
        @(negedge clk); alufn = ALU_MUL; a = 32'd6; b = 32'd7; start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("hold_busy", 32'(busy), 32'd1);
        @(negedge clk); start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("hold_ndone", 32'(done_cnt - d0), 32'd1);
        check_eq("hold_r",     r,                  32'd42);

        // async reset at cycle 20 of a DIV
        @(negedge clk); alufn = ALU_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(ready), 32'd1);
        check_eq("arst_busy",  32'(busy),  32'd0);
        check_eq("arst_done",  32'(done),  32'd0);
        check_eq("arst_r",     r,          32'd0);
        @(negedge clk); rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("arst_nodone", 32'(done_cnt - d0), 32'd0);
        check_eq("arst_r_hold", r,                  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
